// File: rtl/rv32i_types.sv
// Shared types for the RV32I pipeline control slice: controller state encoding
// and the bubble instruction used when IF/ID is flushed.
package rv32i_types;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } ctrl_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and the stall/flush
// controller (slave): hazard operands, memory requests, enables and counters.
interface pipeline_ctrl_if;

    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_mispredict;

    logic        imem_read;
    logic        imem_resp;
    logic        dmem_read;
    logic        dmem_write;
    logic        dmem_resp;

    logic        imem_read_o;
    logic        dmem_read_o;
    logic        dmem_write_o;

    logic        pc_load;
    logic        if_id_load;
    logic        id_ex_load;
    logic        ex_mem_load;
    logic        mem_wb_load;
    logic        if_id_flush;
    logic        id_ex_flush;

    logic [31:0] perf_stall;
    logic [31:0] perf_flush;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read, ex_mispredict,
        output imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
        input  imem_read_o, dmem_read_o, dmem_write_o,
        input  pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
        input  if_id_flush, id_ex_flush,
        input  perf_stall, perf_flush
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read, ex_mispredict,
        input  imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
        output imem_read_o, dmem_read_o, dmem_write_o,
        output pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
        output if_id_flush, id_ex_flush,
        output perf_stall, perf_flush
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register a
// load in EX is about to write. x0 never creates a dependency.
module hazard_detect (
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_mem_read,
    output logic       o_lu
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_lu      = i_ex_mem_read && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: freezes all stages while a cache access is
// outstanding, then applies mispredict flush or load-use bubble.
module pipeline_ctrl
    import rv32i_types::*;
(
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);

    ctrl_state_e r_state;
    logic        r_imem_done;
    logic        r_dmem_done;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    logic        w_lu;
    logic        w_ipend;
    logic        w_dpend;
    logic        w_busy;

    hazard_detect u_hazard_detect (
        .i_id_rs1      (bus.id_rs1),
        .i_id_rs2      (bus.id_rs2),
        .i_id_uses_rs1 (bus.id_uses_rs1),
        .i_id_uses_rs2 (bus.id_uses_rs2),
        .i_ex_rd       (bus.ex_rd),
        .i_ex_mem_read (bus.ex_mem_read),
        .o_lu          (w_lu)
    );

    // A response arriving this cycle already counts as completion.
    assign w_ipend = bus.imem_read && !r_imem_done && !bus.imem_resp;
    assign w_dpend = (bus.dmem_read || bus.dmem_write) && !r_dmem_done && !bus.dmem_resp;
    assign w_busy  = w_ipend || w_dpend;

    assign bus.imem_read_o  = bus.imem_read  && !r_imem_done;
    assign bus.dmem_read_o  = bus.dmem_read  && !r_dmem_done;
    assign bus.dmem_write_o = bus.dmem_write && !r_dmem_done;

    assign bus.perf_stall = r_perf_stall;
    assign bus.perf_flush = r_perf_flush;

    always_comb begin
        // NOTE: every output gets a default first so no path through the if-chain infers a latch.
        bus.pc_load     = 1'b1;
        bus.if_id_load  = 1'b1;
        bus.id_ex_load  = 1'b1;
        bus.ex_mem_load = 1'b1;
        bus.mem_wb_load = 1'b1;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        if (w_busy) begin
            bus.pc_load     = 1'b0;
            bus.if_id_load  = 1'b0;
            bus.id_ex_load  = 1'b0;
            bus.ex_mem_load = 1'b0;
            bus.mem_wb_load = 1'b0;
        end else if (bus.ex_mispredict) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (w_lu) begin
            bus.pc_load     = 1'b0;
            bus.if_id_load  = 1'b0;
            bus.id_ex_flush = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_imem_done  <= 1'b0;
            r_dmem_done  <= 1'b0;
            r_perf_stall <= 32'd0;
            r_perf_flush <= 32'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_busy) begin
                        r_state     <= WAIT;
                        r_imem_done <= bus.imem_read && bus.imem_resp;
                        r_dmem_done <= (bus.dmem_read || bus.dmem_write) && bus.dmem_resp;
                    end
                end
                WAIT: begin
                    if (w_busy) begin
                        r_imem_done <= r_imem_done || (bus.imem_read && bus.imem_resp);
                        r_dmem_done <= r_dmem_done ||
                                       ((bus.dmem_read || bus.dmem_write) && bus.dmem_resp);
                    end else begin
                        r_state     <= RUN;
                        r_imem_done <= 1'b0;
                        r_dmem_done <= 1'b0;
                    end
                end
                default: r_state <= RUN;
            endcase

            if (w_busy) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end else if (bus.ex_mispredict) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: single-cycle decision table from RUN plus
// multi-cycle memory-wait, mispredict-under-freeze and reset-in-wait sequences.
module tb_pipeline_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] ex_rd;
        logic       mr;
        logic       mis;
        logic       ir;
        logic       iresp;
        logic       dr;
        logic       dw;
        logic       dresp;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [4:0] loads;
        logic [1:0] flush;
        logic [2:0] gate;
    } vec_t;

    localparam logic       H    = 1'b1;
    localparam logic       L    = 1'b0;
    localparam logic [4:0] ALL  = 5'b11111;
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] LUB  = 5'b00111;
    localparam in_t        IDLE = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[14];

    always #5 clk = ~clk;

    pipeline_ctrl_if bus ();

    pipeline_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic in_t mk(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                               logic [4:0] ex_rd, logic mr, logic mis, logic ir,
                               logic iresp, logic dr, logic dw, logic dresp);
        in_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.ex_rd = ex_rd;
        v.mr = mr; v.mis = mis; v.ir = ir; v.iresp = iresp;
        v.dr = dr; v.dw = dw; v.dresp = dresp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        bus.id_rs1        = v.rs1;
        bus.id_rs2        = v.rs2;
        bus.id_uses_rs1   = v.u1;
        bus.id_uses_rs2   = v.u2;
        bus.ex_rd         = v.ex_rd;
        bus.ex_mem_read   = v.mr;
        bus.ex_mispredict = v.mis;
        bus.imem_read     = v.ir;
        bus.imem_resp     = v.iresp;
        bus.dmem_read     = v.dr;
        bus.dmem_write    = v.dw;
        bus.dmem_resp     = v.dresp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, compare the combinational controls mid-cycle, then cross the edge.
    task automatic step_check(input string name, input in_t v, input logic [4:0] el,
                              input logic [1:0] ef, input logic [2:0] eg);
        drive(v);
        @(negedge clk);
        check({name, ".loads"}, 32'({bus.pc_load, bus.if_id_load, bus.id_ex_load,
                                     bus.ex_mem_load, bus.mem_wb_load}), 32'(el));
        check({name, ".flush"}, 32'({bus.if_id_flush, bus.id_ex_flush}), 32'(ef));
        check({name, ".gate"},  32'({bus.imem_read_o, bus.dmem_read_o, bus.dmem_write_o}), 32'(eg));
        tick();
    endtask

    task automatic check_counters(input string name, input logic [31:0] es, input logic [31:0] ef);
        @(negedge clk);
        check({name, ".perf_stall"}, bus.perf_stall, es);
        check({name, ".perf_flush"}, bus.perf_flush, ef);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(IDLE);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"idle",        IDLE,                                                   ALL,  2'b00, 3'b000};
        vecs[1]  = '{"lu_rs2",      mk(5'd0, 5'd5, L, H, 5'd5, H, L, L, L, L, L, L),        LUB,  2'b01, 3'b000};
        vecs[2]  = '{"lu_rs1",      mk(5'd7, 5'd0, H, L, 5'd7, H, L, L, L, L, L, L),        LUB,  2'b01, 3'b000};
        vecs[3]  = '{"rs2_unused",  mk(5'd0, 5'd5, L, L, 5'd5, H, L, L, L, L, L, L),        ALL,  2'b00, 3'b000};
        vecs[4]  = '{"rd_x0",       mk(5'd0, 5'd0, H, H, 5'd0, H, L, L, L, L, L, L),        ALL,  2'b00, 3'b000};
        vecs[5]  = '{"not_load",    mk(5'd0, 5'd5, L, H, 5'd5, L, L, L, L, L, L, L),        ALL,  2'b00, 3'b000};
        vecs[6]  = '{"lu_mispred",  mk(5'd0, 5'd5, L, H, 5'd5, H, H, L, L, L, L, L),        ALL,  2'b11, 3'b000};
        vecs[7]  = '{"mispred",     mk(5'd0, 5'd0, L, L, 5'd0, L, H, L, L, L, L, L),        ALL,  2'b11, 3'b000};
        vecs[8]  = '{"imem_hit",    mk(5'd0, 5'd0, L, L, 5'd0, L, L, H, H, L, L, L),        ALL,  2'b00, 3'b100};
        vecs[9]  = '{"imem_miss",   mk(5'd0, 5'd0, L, L, 5'd0, L, L, H, L, L, L, L),        NONE, 2'b00, 3'b100};
        vecs[10] = '{"dw_miss_mis", mk(5'd0, 5'd0, L, L, 5'd0, L, H, L, L, L, H, L),        NONE, 2'b00, 3'b001};
        vecs[11] = '{"dr_hit_lu",   mk(5'd0, 5'd5, L, H, 5'd5, H, L, L, L, H, L, H),        LUB,  2'b01, 3'b010};
        vecs[12] = '{"busy_lu",     mk(5'd0, 5'd5, L, H, 5'd5, H, L, H, L, L, L, L),        NONE, 2'b00, 3'b100};
        vecs[13] = '{"lu_rs1_only", mk(5'd3, 5'd4, H, H, 5'd3, H, L, L, L, L, L, L),        LUB,  2'b01, 3'b000};

        drive(IDLE);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_counters("reset", 32'd0, 32'd0);
        tick();
        step_check("reset_idle", IDLE, ALL, 2'b00, 3'b000);

        // Decision table; an idle cycle afterwards always returns the FSM to RUN with clear flags.
        for (int i = 0; i < 14; i++) begin
            step_check(vecs[i].name, vecs[i].in, vecs[i].loads, vecs[i].flush, vecs[i].gate);
            drive(IDLE);
            tick();
        end

        // imem miss for three cycles, response on the fourth.
        do_reset();
        for (int c = 0; c < 3; c++)
            step_check($sformatf("imiss_c%0d", c), mk(5'd0, 5'd0, L, L, 5'd0, L, L, H, L, L, L, L),
                       NONE, 2'b00, 3'b100);
        step_check("imiss_resp", mk(5'd0, 5'd0, L, L, 5'd0, L, L, H, H, L, L, L), ALL, 2'b00, 3'b100);
        drive(IDLE);
        check_counters("imiss", 32'd3, 32'd0);
        tick();

        // dmem answers at cycle 1 and must not be re-issued; imem answers at cycle 4.
        do_reset();
        step_check("dual_c0", mk(5'd0, 5'd0, L, L, 5'd0, L, L, H, L, H, L, L), NONE, 2'b00, 3'b110);
        step_check("dual_c1", mk(5'd0, 5'd0, L, L, 5'd0, L, L, H, L, H, L, H), NONE, 2'b00, 3'b110);
        step_check("dual_c2", mk(5'd0, 5'd0, L, L, 5'd0, L, L, H, L, H, L, L), NONE, 2'b00, 3'b100);
        step_check("dual_c3", mk(5'd0, 5'd0, L, L, 5'd0, L, L, H, L, H, L, L), NONE, 2'b00, 3'b100);
        step_check("dual_c4", mk(5'd0, 5'd0, L, L, 5'd0, L, L, H, H, H, L, L), ALL,  2'b00, 3'b100);
        // A fresh dmem request after release must be issued again (dmem_done cleared).
        step_check("dual_c5", mk(5'd0, 5'd0, L, L, 5'd0, L, L, L, L, H, L, L), NONE, 2'b00, 3'b010);
        step_check("dual_c6", mk(5'd0, 5'd0, L, L, 5'd0, L, L, L, L, H, L, H), ALL,  2'b00, 3'b010);
        drive(IDLE);
        check_counters("dual", 32'd5, 32'd0);
        tick();

        // Mispredict held during a two-cycle dmem wait: flushed only on release, counted once.
        do_reset();
        step_check("mfrz_c0", mk(5'd0, 5'd0, L, L, 5'd0, L, H, L, L, H, L, L), NONE, 2'b00, 3'b010);
        step_check("mfrz_c1", mk(5'd0, 5'd0, L, L, 5'd0, L, H, L, L, H, L, L), NONE, 2'b00, 3'b010);
        step_check("mfrz_c2", mk(5'd0, 5'd0, L, L, 5'd0, L, H, L, L, H, L, H), ALL,  2'b11, 3'b010);
        drive(IDLE);
        check_counters("mfrz", 32'd2, 32'd1);
        tick();
        step_check("mis_run", mk(5'd0, 5'd0, L, L, 5'd0, L, H, L, L, L, L, L), ALL, 2'b11, 3'b000);
        drive(IDLE);
        check_counters("mis_run", 32'd2, 32'd2);
        tick();

        // Reset while waiting with dmem_done set.
        step_check("rw_c0", mk(5'd0, 5'd0, L, L, 5'd0, L, L, H, L, H, L, L), NONE, 2'b00, 3'b110);
        step_check("rw_c1", mk(5'd0, 5'd0, L, L, 5'd0, L, L, H, L, H, L, H), NONE, 2'b00, 3'b110);
        drive(mk(5'd0, 5'd0, L, L, 5'd0, L, L, H, L, H, L, L));
        @(negedge clk);
        check("rw_c2.dmem_read_o", 32'(bus.dmem_read_o), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_counters("rw_after", 32'd0, 32'd0);
        // Stale responses with no request must not set a flag.
        step_check("rw_stale", mk(5'd0, 5'd0, L, L, 5'd0, L, L, L, H, L, L, H), ALL, 2'b00, 3'b000);
        step_check("rw_reissue", mk(5'd0, 5'd0, L, L, 5'd0, L, L, H, L, H, L, L), NONE, 2'b00, 3'b110);
        drive(IDLE);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
